// File: rtl/mlsu_req_arbiter.sv
// rtl/mlsu_req_arbiter.sv - round-robin arbiter in front of the MLSU request pre-decoder
// Holds each grant until the pre-decoder's last tile; caps and direction-locks in-flight requests.
module mlsu_req_arbiter #(
   parameter int NUM_REQ         = 2,
   parameter int MAX_OUTSTANDING = 4,
   parameter type mlsu_init_req_t = logic,
   localparam int SW = $clog2(NUM_REQ),
   localparam int CW = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   input  logic [NUM_REQ-1:0]   req_is_load_i,
   input  mlsu_init_req_t       req_i [NUM_REQ],
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output mlsu_init_req_t       out_o,
   output logic [SW-1:0]        out_src_o,
   input  logic                 cpl_valid_i,
   output logic [CW-1:0]        outstanding_o,
   output logic                 idle_o
);

   typedef logic [CW-1:0] cnt_t;
   typedef enum logic {S_IDLE = 1'b0, S_LOCKED = 1'b1} state_t;

   state_t          r_state;
   logic [SW-1:0]   r_grant;
   logic [SW-1:0]   r_rr_ptr;
   cnt_t            r_cnt;
   logic            r_dir;

   logic [NUM_REQ-1:0] w_elig;
   logic               w_has_room;
   logic               w_found;
   logic [SW-1:0]      w_pick;
   int                 w_j;
   logic               w_acc;
   cnt_t               w_cnt_nxt;

   // A mismatched direction is only eligible once the pipe has fully drained.
   always_comb begin
      w_has_room = (r_cnt < cnt_t'(MAX_OUTSTANDING));
      for (int k = 0; k < NUM_REQ; k++) begin
         w_elig[k] = req_valid_i[k] && w_has_room &&
                     ((r_cnt == '0) || (req_is_load_i[k] == r_dir));
      end
   end

   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_j     = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_j = int'(r_rr_ptr) + i;
         if (w_j >= NUM_REQ) w_j = w_j - NUM_REQ;
         if (!w_found && w_elig[w_j]) begin
            w_found = 1'b1;
            w_pick  = SW'(w_j);
         end
      end
   end

   assign w_acc = (r_state == S_LOCKED) && out_ready_i;

   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_acc && !cpl_valid_i) begin
         w_cnt_nxt = r_cnt + cnt_t'(1);
      end else if (!w_acc && cpl_valid_i && (r_cnt != '0)) begin
         w_cnt_nxt = r_cnt - cnt_t'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= S_IDLE;
         r_grant  <= '0;
         r_rr_ptr <= '0;
         r_cnt    <= '0;
         r_dir    <= 1'b0;
      end else begin
         if (r_state == S_IDLE) begin
            if (w_found) begin
               r_grant <= w_pick;
               r_dir   <= req_is_load_i[w_pick];
               r_state <= S_LOCKED;
            end
         end else if (out_ready_i) begin
            r_rr_ptr <= (r_grant == SW'(NUM_REQ - 1)) ? '0 : r_grant + SW'(1);
            r_state  <= S_IDLE;
         end
         r_cnt <= w_cnt_nxt;
      end
   end

   always_comb begin
      for (int k = 0; k < NUM_REQ; k++) begin
         req_ready_o[k] = (r_state == S_LOCKED) && (r_grant == SW'(k)) && out_ready_i;
      end
   end

   assign out_valid_o   = (r_state == S_LOCKED);
   assign out_o         = req_i[r_grant];
   assign out_src_o     = r_grant;
   assign outstanding_o = r_cnt;
   assign idle_o        = (r_state == S_IDLE) && (r_cnt == '0);

   a_valid_hold: assert property (@(posedge clk_i) disable iff (rst_i)
      (out_valid_o && !out_ready_i) |=> out_valid_o);
   a_one_ready: assert property (@(posedge clk_i) disable iff (rst_i)
      $countones(req_ready_o) <= 1);
   a_cnt_max: assert property (@(posedge clk_i) disable iff (rst_i)
      r_cnt <= cnt_t'(MAX_OUTSTANDING));
   a_cpl_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
      (cpl_valid_i && (r_cnt == '0)) |-> w_acc)
      else $warning("cpl_valid_i with no request outstanding");

endmodule

// File: tb/tb_mlsu_req_arbiter.sv
// tb/tb_mlsu_req_arbiter.sv - directed bench for mlsu_req_arbiter with a per-cycle reference model
module tb_mlsu_req_arbiter;

   localparam int N   = 2;
   localparam int MAX = 4;
   typedef logic [7:0] pay_t;

   logic          clk = 1'b0;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N-1:0]  req_ready;
   logic [N-1:0]  req_is_load;
   pay_t          req [N];
   logic          out_valid;
   logic          out_ready;
   pay_t          out_pay;
   logic [0:0]    out_src;
   logic          cpl_valid;
   logic [2:0]    outstanding;
   logic          idle;

   int n_cmp = 0;
   int n_bad = 0;

   mlsu_req_arbiter #(
      .NUM_REQ(N), .MAX_OUTSTANDING(MAX), .mlsu_init_req_t(pay_t)
   ) dut (
      .clk_i(clk), .rst_i(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready),
      .req_is_load_i(req_is_load), .req_i(req),
      .out_valid_o(out_valid), .out_ready_i(out_ready),
      .out_o(out_pay), .out_src_o(out_src),
      .cpl_valid_i(cpl_valid), .outstanding_o(outstanding), .idle_o(idle)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: whether a request is being presented, to whom, and how many are in flight.
   bit m_live = 0;
   bit m_busy = 0;
   int m_grant = 0;
   int m_rr = 0;
   int m_cnt = 0;
   bit m_dir = 0;

   always @(posedge clk) begin
      bit acc;
      bit found;
      m_live = 1;
      if (rst) begin
         m_busy = 0; m_grant = 0; m_rr = 0; m_cnt = 0; m_dir = 0;
      end else begin
         acc = m_busy && out_ready;
         if (m_busy) begin
            if (out_ready) begin
               m_busy = 0;
               m_rr = (m_grant + 1) % N;
            end
         end else begin
            found = 0;
            for (int i = 0; i < N; i++) begin
               int k;
               k = (m_rr + i) % N;
               if (!found && req_valid[k] && m_cnt < MAX &&
                   (m_cnt == 0 || req_is_load[k] == m_dir)) begin
                  found = 1; m_busy = 1; m_grant = k; m_dir = req_is_load[k];
               end
            end
         end
         if (acc) m_cnt = m_cnt + 1;
         if (cpl_valid && (m_cnt > 0)) m_cnt = m_cnt - 1;
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         logic [N-1:0] exp_rdy;
         exp_rdy = '0;
         if (m_busy && out_ready) exp_rdy[m_grant] = 1'b1;
         check("model_out_valid", 32'(out_valid), 32'(m_busy));
         check("model_req_ready", 32'(req_ready), 32'(exp_rdy));
         check("model_outstanding", 32'(outstanding), 32'(m_cnt));
         check("model_idle", 32'(idle), 32'(!m_busy && m_cnt == 0));
         if (m_busy) begin
            check("model_out_src", 32'(out_src), 32'(m_grant));
            check("model_out_payload", 32'(out_pay), 32'(req[m_grant]));
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1; req_valid = '0; req_is_load = '0; out_ready = 0; cpl_valid = 0;
      req[0] = 8'hA0; req[1] = 8'hB1;
      tick(2);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_out_src", 32'(out_src), 0);
      check("rst_outstanding", 32'(outstanding), 0);
      check("rst_idle", 32'(idle), 1);

      // both loads valid: alternate 0,1,0,1 until four are in flight
      rst = 0; req_valid = 2'b11; req_is_load = 2'b11;
      tick(1);
      out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         check("rr_valid", 32'(out_valid), 1);
         check("rr_src", 32'(out_src), 32'(i % 2));
         tick(1);
         check("rr_cnt", 32'(outstanding), 32'(i + 1));
         if (i < 3) tick(1);
      end

      // full pipe: fifth load waits until one completion
      out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         check("full_no_grant", 32'(out_valid), 0);
      end
      check("full_cnt", 32'(outstanding), 4);
      cpl_valid = 1; tick(1); cpl_valid = 0;
      check("cpl_cnt", 32'(outstanding), 3);
      check("cpl_same_cycle_valid", 32'(out_valid), 0);
      tick(1);
      check("cpl_grant_valid", 32'(out_valid), 1);
      check("cpl_grant_src", 32'(out_src), 0);

      // grant held across a stalled pre-decoder while req1 raises valid
      req_valid = 2'b01;
      for (int c = 1; c <= 5; c++) begin
         if (c == 2) req_valid = 2'b11;
         tick(1);
         check("hold_src", 32'(out_src), 0);
         check("hold_ready", 32'(req_ready), 0);
         check("hold_valid", 32'(out_valid), 1);
      end
      out_ready = 1; #1;
      check("hold_release_ready", 32'(req_ready), 32'(2'b01));
      tick(1); out_ready = 0;

      // accept and completion in the same cycle at cnt=3
      cpl_valid = 1; tick(1); cpl_valid = 0;
      tick(1);
      check("simul_src", 32'(out_src), 1);
      out_ready = 1; cpl_valid = 1; tick(1);
      out_ready = 0; cpl_valid = 0;
      check("simul_cnt", 32'(outstanding), 3);

      // store on req1 waits for the load pipe to drain
      req_valid = 2'b10; req_is_load = 2'b01; cpl_valid = 1;
      tick(1); cpl_valid = 0;
      tick(2);
      check("dir_wait_valid", 32'(out_valid), 0);
      check("dir_wait_cnt", 32'(outstanding), 2);
      cpl_valid = 1; tick(2); cpl_valid = 0;
      check("dir_drain_cnt", 32'(outstanding), 0);
      check("dir_drain_valid", 32'(out_valid), 0);
      tick(1);
      check("dir_store_src", 32'(out_src), 1);
      check("dir_store_payload", 32'(out_pay), 32'h0B1);
      req_valid = 2'b01; out_ready = 1;
      tick(1); out_ready = 0;
      tick(2);
      check("dir_load_blocked", 32'(out_valid), 0);

      // completion with nothing outstanding saturates at zero
      req_valid = 2'b00; cpl_valid = 1;
      tick(2); cpl_valid = 0;
      check("underflow_cnt", 32'(outstanding), 0);
      check("underflow_idle", 32'(idle), 1);

      // reset while locked with two in flight
      req_valid = 2'b01;
      tick(1); out_ready = 1;
      tick(3); out_ready = 0;
      tick(1);
      check("pre_rst_valid", 32'(out_valid), 1);
      check("pre_rst_cnt", 32'(outstanding), 2);
      rst = 1; tick(1);
      check("mid_rst_valid", 32'(out_valid), 0);
      check("mid_rst_cnt", 32'(outstanding), 0);
      check("mid_rst_idle", 32'(idle), 1);
      rst = 0; req_valid = 2'b00;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
